// File: rtl/sdram_arbiter.sv
// Arbiter/scheduler in front of the SDRAM command engine: shares the device between
// a priority read port and a write port, and interleaves periodic auto-refresh.
module sdram_arbiter #(
    parameter int ADDR_W           = 22,
    parameter int REFRESH_INTERVAL = 1290,
    parameter int URGENT_LEVEL     = 4,
    parameter int READ_STREAK_MAX  = 4
) (
    input  logic              dram_clk,
    input  logic              reset,
    input  logic              ctrl_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [15:0]       rd_data,
    output logic              rd_data_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [1:0]        wr_mask,
    output logic              wr_ack,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [15:0]       cmd_wdata,
    output logic [1:0]        cmd_mask,
    input  logic              cmd_ready,
    input  logic              resp_valid,
    input  logic [15:0]       resp_data,
    output logic [2:0]        refresh_pending,
    output logic              busy
);

    localparam int CNT_W    = $clog2(REFRESH_INTERVAL);
    localparam int STREAK_W = $clog2(READ_STREAK_MAX + 1);

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [2:0]          URGENT     = 3'(URGENT_LEVEL);
    localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(READ_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_REFRESH = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_READ,
        GNT_WRITE,
        GNT_REFRESH
    } grant_t;

    state_t               state;
    state_t               state_nxt;
    grant_t               grant;
    op_t                  op_q;
    logic [CNT_W-1:0]     interval_cnt;
    logic [STREAK_W-1:0]  streak;
    logic                 tick;
    logic                 cmd_hs;
    logic                 refresh_hs;

    // State register
    always_ff @(posedge dram_clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Grant priority; only considered in IDLE once the SDRAM is initialised
    always_comb begin
        grant = GNT_NONE;
        if (state == IDLE && ctrl_ready) begin
            if (refresh_pending >= URGENT)
                grant = GNT_REFRESH;
            else if (wr_req && streak == STREAK_TOP)
                grant = GNT_WRITE;
            else if (rd_req)
                grant = GNT_READ;
            else if (wr_req)
                grant = GNT_WRITE;
            else if (refresh_pending != 3'd0)
                grant = GNT_REFRESH;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (grant != GNT_NONE) state_nxt = ISSUE;
            ISSUE:     if (cmd_ready) state_nxt = (op_q == OP_READ) ? WAIT_RESP : IDLE;
            WAIT_RESP: if (resp_valid) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_valid  = (state == ISSUE);
        cmd_op     = op_q;
        cmd_hs     = cmd_valid && cmd_ready;
        refresh_hs = cmd_hs && (op_q == OP_REFRESH);
        tick       = ctrl_ready && (interval_cnt == CNT_LAST);
    end

    // Command capture, acks, read return and read-streak tracking
    always_ff @(posedge dram_clk) begin
        if (reset) begin
            op_q          <= OP_READ;
            cmd_addr      <= '0;
            cmd_wdata     <= '0;
            cmd_mask      <= '0;
            rd_ack        <= 1'b0;
            wr_ack        <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            streak        <= '0;
        end else begin
            rd_ack        <= cmd_hs && (op_q == OP_READ);
            wr_ack        <= cmd_hs && (op_q == OP_WRITE);
            rd_data_valid <= (state == WAIT_RESP) && resp_valid;
            if (state == WAIT_RESP && resp_valid)
                rd_data <= resp_data;

            unique case (grant)
                GNT_READ: begin
                    op_q      <= OP_READ;
                    cmd_addr  <= rd_addr;
                    cmd_wdata <= '0;
                    cmd_mask  <= '0;
                    streak    <= wr_req ? streak + 1'b1 : '0;
                end
                GNT_WRITE: begin
                    op_q      <= OP_WRITE;
                    cmd_addr  <= wr_addr;
                    cmd_wdata <= wr_data;
                    cmd_mask  <= wr_mask;
                    streak    <= '0;
                end
                GNT_REFRESH: begin
                    op_q      <= OP_REFRESH;
                    cmd_addr  <= '0;
                    cmd_wdata <= '0;
                    cmd_mask  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Refresh interval and debt; a tick coinciding with a refresh handshake cancels out
    always_ff @(posedge dram_clk) begin
        if (reset || !ctrl_ready) begin
            interval_cnt    <= '0;
            refresh_pending <= '0;
        end else begin
            interval_cnt <= tick ? '0 : interval_cnt + 1'b1;
            if (tick && !refresh_hs) begin
                if (refresh_pending != 3'd7)
                    refresh_pending <= refresh_pending + 3'd1;
            end else if (!tick && refresh_hs && refresh_pending != 3'd0) begin
                refresh_pending <= refresh_pending - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected commands and read data are queued as
// stimulus is driven and retired as the arbiter issues/returns them.
module tb_sdram_arbiter;

    localparam int ADDR_W = 22;

    logic              dram_clk = 1'b0;
    logic              reset, ctrl_ready;
    logic              rd_req, rd_ack, rd_data_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic              wr_req, wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [1:0]        wr_mask;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op, cmd_mask;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_wdata;
    logic              resp_valid;
    logic [15:0]       resp_data;
    logic [2:0]        refresh_pending;
    logic              busy;

    always #5 dram_clk = ~dram_clk;

    sdram_arbiter #(
        .ADDR_W(ADDR_W), .REFRESH_INTERVAL(16), .URGENT_LEVEL(4), .READ_STREAK_MAX(4)
    ) dut (
        .dram_clk(dram_clk), .reset(reset), .ctrl_ready(ctrl_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_ack(wr_ack),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_mask(cmd_mask), .cmd_ready(cmd_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .refresh_pending(refresh_pending), .busy(busy)
    );

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
        logic [1:0]        mask;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [15:0] exp_rd[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        hs_seen = 1'b0;
    logic [1:0]  hs_op = 2'b00;
    bit          auto_resp = 1'b0;
    bit          auto_driven = 1'b0;
    int          resp_cd = 0;
    logic [15:0] auto_data = 16'h0000;

    task automatic push_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                            input logic [15:0] wdata, input logic [1:0] mask);
        cmd_t c;
        c.op = op; c.addr = addr; c.wdata = wdata; c.mask = mask;
        exp_cmd.push_back(c);
    endtask

    // Retire any handshake/read return about to happen, advance to the next negedge,
    // then run the automatic read responder.
    task automatic step();
        cmd_t        e;
        logic [15:0] d;
        hs_seen = 1'b0;
        if (reset === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            hs_seen = 1'b1;
            hs_op   = cmd_op;
            checks++;
            if (exp_cmd.size() == 0) begin
                failures++;
                $display("FAIL cmd_unexpected: got op=%0d addr=%h wdata=%h mask=%b, none expected",
                         cmd_op, cmd_addr, cmd_wdata, cmd_mask);
            end else begin
                e = exp_cmd.pop_front();
                if (cmd_op !== e.op || cmd_addr !== e.addr || cmd_wdata !== e.wdata || cmd_mask !== e.mask) begin
                    failures++;
                    $display("FAIL cmd_fields: got op=%0d addr=%h wdata=%h mask=%b, expected op=%0d addr=%h wdata=%h mask=%b",
                             cmd_op, cmd_addr, cmd_wdata, cmd_mask, e.op, e.addr, e.wdata, e.mask);
                end
            end
            if (auto_resp && cmd_op == 2'b00) resp_cd = 3;
        end
        if (rd_data_valid === 1'b1) begin
            checks++;
            if (exp_rd.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: rd_data_valid with rd_data=%h, none expected", rd_data);
            end else begin
                d = exp_rd.pop_front();
                if (rd_data !== d) begin
                    failures++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, d);
                end
            end
        end
        @(negedge dram_clk);
        cyc++;
        if (auto_driven) begin
            resp_valid  = 1'b0;
            auto_driven = 1'b0;
        end
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
                resp_valid  = 1'b1;
                resp_data   = auto_data;
                exp_rd.push_back(auto_data);
                auto_data   = auto_data + 16'h1111;
                auto_driven = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ctrl_ready = 1'b0; cmd_ready = 1'b0;
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        resp_valid = 1'b0; resp_data = '0;
        auto_resp = 1'b0; resp_cd = 0; auto_driven = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        do_reset();
        reset = 1'b1; rd_req = 1'b1; rd_addr = 22'h12345;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rd_ack, wr_ack, rd_data,
             rd_data_valid, refresh_pending, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: cmd_valid=%b op=%0d addr=%h rd_ack=%b wr_ack=%b rdv=%b pend=%0d busy=%b, expected all 0",
                     cmd_valid, cmd_op, cmd_addr, rd_ack, wr_ack, rd_data_valid, refresh_pending, busy);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            if (cmd_valid !== 1'b0 || refresh_pending !== 3'd0 || busy !== 1'b0 || rd_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL gating: %0d cycles with activity while ctrl_ready=0, expected 0", bad);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        ctrl_ready = 1'b1; cmd_ready = 1'b1; rd_req = 1'b1; rd_addr = 22'h12345;
        push_cmd(2'b00, 22'h12345, 16'h0, 2'b00);
        step();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 2'b00 || cmd_addr !== 22'h12345) begin
            failures++;
            $display("FAIL rd_issue: cmd_valid=%b op=%0d addr=%h, expected 1/0/012345", cmd_valid, cmd_op, cmd_addr);
        end
        step();
        checks++;
        if (rd_ack !== 1'b1 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_ack: rd_ack=%b cmd_valid=%b, expected 1/0", rd_ack, cmd_valid);
        end
        rd_req = 1'b0;
        step();
        checks++;
        if (rd_ack !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rd_ack_pulse: rd_ack=%b busy=%b, expected 0/1", rd_ack, busy);
        end
        resp_valid = 1'b1; resp_data = 16'hBEEF;
        exp_rd.push_back(16'hBEEF);
        step();
        resp_valid = 1'b0;
        checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL rd_return: rdv=%b rd_data=%h, expected 1/beef", rd_data_valid, rd_data);
        end
        step();
        checks++;
        if (rd_data_valid !== 1'b0 || rd_data !== 16'hBEEF || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_hold: rdv=%b rd_data=%h busy=%b, expected 0/beef/0", rd_data_valid, rd_data, busy);
        end
        ctrl_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int acks = 0;
        int n = 0;
        do_reset();
        ctrl_ready = 1'b1; cmd_ready = 1'b1; auto_resp = 1'b1; auto_data = 16'h1000;
        rd_addr = 22'h000100; wr_addr = 22'h3F0200; wr_data = 16'hA55A; wr_mask = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push_cmd(2'b01, 22'h3F0200, 16'hA55A, 2'b10);
            else            push_cmd(2'b00, 22'h000100, 16'h0000, 2'b00);
        end
        rd_req = 1'b1; wr_req = 1'b1;
        while (n < 400 && acks < 10) begin
            step();
            n++;
            if (rd_ack === 1'b1 || wr_ack === 1'b1) acks++;
            if (acks == 10) begin
                rd_req = 1'b0; wr_req = 1'b0; ctrl_ready = 1'b0;
            end
        end
        rd_req = 1'b0; wr_req = 1'b0; ctrl_ready = 1'b0;
        checks++;
        if (acks != 10) begin
            failures++;
            $display("FAIL fair_timeout: got %0d acks, expected 10", acks);
        end
        repeat (4) step();
        auto_resp = 1'b0;
        checks++;
        if (exp_cmd.size() != 0 || exp_rd.size() != 0) begin
            failures++;
            $display("FAIL fair_drain: %0d cmds %0d reads left, expected 0/0", exp_cmd.size(), exp_rd.size());
        end
    endtask

    task automatic test_refresh();
        int n = 0;
        int prev = 0;
        do_reset();
        ctrl_ready = 1'b1; cmd_ready = 1'b1;
        repeat (4) push_cmd(2'b10, '0, 16'h0, 2'b00);
        for (int k = 0; k < 120 && n < 4; k++) begin
            step();
            if (hs_seen && hs_op == 2'b10) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - prev != 16) begin
                        failures++;
                        $display("FAIL refresh_period: got %0d cycles expected 16", cyc - prev);
                    end
                end
                checks++;
                if (refresh_pending !== 3'd0) begin
                    failures++;
                    $display("FAIL refresh_drain: pending=%0d expected 0", refresh_pending);
                end
                prev = cyc;
                n++;
            end
        end
        ctrl_ready = 1'b0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL refresh_timeout: got %0d refreshes expected 4", n);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ctrl_ready = 1'b1; cmd_ready = 1'b0;
        push_cmd(2'b10, '0, 16'h0, 2'b00);
        repeat (200) step();
        checks++;
        if (refresh_pending !== 3'd7 || cmd_valid !== 1'b1 || cmd_op !== 2'b10) begin
            failures++;
            $display("FAIL saturate: pending=%0d cmd_valid=%b op=%0d, expected 7/1/2", refresh_pending, cmd_valid, cmd_op);
        end
        ctrl_ready = 1'b0;
        step();
        checks++;
        if (refresh_pending !== 3'd0 || cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL gate_inflight: pending=%0d cmd_valid=%b, expected 0/1", refresh_pending, cmd_valid);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        checks++;
        if (refresh_pending !== 3'd0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL inflight_done: pending=%0d busy=%b cmd_valid=%b, expected 0/0/0", refresh_pending, busy, cmd_valid);
        end
    endtask

    task automatic test_urgent();
        int n = 0;
        do_reset();
        ctrl_ready = 1'b1; cmd_ready = 1'b1; rd_req = 1'b1; rd_addr = 22'h0ABCDE;
        push_cmd(2'b00, 22'h0ABCDE, 16'h0, 2'b00);
        n = 0;
        while (n < 20 && rd_ack !== 1'b1) begin step(); n++; end
        rd_addr = 22'h155555;
        push_cmd(2'b10, '0, 16'h0, 2'b00);
        push_cmd(2'b00, 22'h155555, 16'h0, 2'b00);
        n = 0;
        while (n < 200 && refresh_pending !== 3'd4) begin step(); n++; end
        checks++;
        if (refresh_pending !== 3'd4 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL urgent_setup: pending=%0d busy=%b cmd_valid=%b, expected 4/1/0", refresh_pending, busy, cmd_valid);
        end
        resp_valid = 1'b1; resp_data = 16'h0F0F;
        exp_rd.push_back(16'h0F0F);
        step();
        resp_valid = 1'b0;
        n = 0;
        while (n < 20 && rd_ack !== 1'b1) begin step(); n++; end
        checks++;
        if (rd_ack !== 1'b1 || refresh_pending !== 3'd3) begin
            failures++;
            $display("FAIL urgent_then_read: rd_ack=%b pending=%0d, expected 1/3", rd_ack, refresh_pending);
        end
        rd_req = 1'b0; ctrl_ready = 1'b0;
        resp_valid = 1'b1; resp_data = 16'hF0F0;
        exp_rd.push_back(16'hF0F0);
        step();
        resp_valid = 1'b0;
        step(); step();
        checks++;
        if (exp_cmd.size() != 0 || exp_rd.size() != 0) begin
            failures++;
            $display("FAIL urgent_drain: %0d cmds %0d reads left, expected 0/0", exp_cmd.size(), exp_rd.size());
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        ctrl_ready = 1'b1; cmd_ready = 1'b0;
        wr_req = 1'b1; wr_addr = 22'h2A5A5A; wr_data = 16'hC3A5; wr_mask = 2'b01;
        push_cmd(2'b01, 22'h2A5A5A, 16'hC3A5, 2'b01);
        step();
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid !== 1'b1 || cmd_op !== 2'b01 || cmd_addr !== 22'h2A5A5A ||
                cmd_wdata !== 16'hC3A5 || cmd_mask !== 2'b01 || wr_ack !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stable: %0d unstable cycles, expected 0", bad);
        end
        cmd_ready = 1'b1;
        step();
        checks++;
        if (wr_ack !== 1'b1 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack: wr_ack=%b cmd_valid=%b, expected 1/0", wr_ack, cmd_valid);
        end
        wr_req = 1'b0; ctrl_ready = 1'b0; cmd_ready = 1'b0;
        step();
        checks++;
        if (wr_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack_pulse: wr_ack=%b busy=%b, expected 0/0", wr_ack, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        ctrl_ready = 1'b1; cmd_ready = 1'b1; rd_req = 1'b1; rd_addr = 22'h3FFFFF;
        push_cmd(2'b00, 22'h3FFFFF, 16'h0, 2'b00);
        while (n < 20 && rd_ack !== 1'b1) begin step(); n++; end
        rd_req = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_resp_busy: busy=%b expected 1", busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; ctrl_ready = 1'b0;
        checks++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rd_ack, wr_ack, rd_data,
             rd_data_valid, refresh_pending, busy} !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b cmd_valid=%b addr=%h rd_data=%h pend=%0d, expected all 0",
                     busy, cmd_valid, cmd_addr, rd_data, refresh_pending);
        end
        resp_valid = 1'b1; resp_data = 16'h5555;
        step();
        resp_valid = 1'b0;
        checks++;
        if (rd_data_valid !== 1'b0 || rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL stale_resp: rdv=%b rd_data=%h, expected 0/0000", rd_data_valid, rd_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_refresh();
        test_saturation();
        test_urgent();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (exp_cmd.size() != 0 || exp_rd.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: %0d cmds %0d reads outstanding, expected 0/0", exp_cmd.size(), exp_rd.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
